// File: rtl/sprite_line_fetcher.sv
// Prefetches the scanline rows of two 32x32 sprites from a shared ROM during
// horizontal blank, then composites them over the background during active video.
module sprite_line_fetcher #(
    parameter int ADDRESS    = 11,
    parameter int COLOR_BITS = 24,
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 10,
    parameter logic [COLOR_BITS-1:0] TRANSPARENT = 24'hFF00FF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  line_start,
    input  logic [V_BITS-1:0]     next_line,
    input  logic                  active,
    input  logic [H_BITS-1:0]     hcount,
    input  logic                  p0_en,
    input  logic                  p1_en,
    input  logic [H_BITS-1:0]     p0_x,
    input  logic [H_BITS-1:0]     p1_x,
    input  logic [V_BITS-1:0]     p0_y,
    input  logic [V_BITS-1:0]     p1_y,
    input  logic [COLOR_BITS-1:0] bg_color,
    output logic [ADDRESS-1:0]    rom_addr,
    input  logic [COLOR_BITS-1:0] rom_data,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  fetch_busy,
    output logic                  overrun
);
    typedef enum logic [2:0] {IDLE, CHECK0, FETCH0, CHECK1, FETCH1} state_t;

    state_t                  state_reg;
    logic [4:0]              col_reg;
    logic [4:0]              row0_reg;
    logic [4:0]              row1_reg;
    logic                    hit0_reg;
    logic                    hit1_reg;
    logic                    overrun_reg;
    logic                    en0_reg;
    logic                    en1_reg;
    logic [H_BITS-1:0]       x0_reg;
    logic [H_BITS-1:0]       x1_reg;
    logic [V_BITS-1:0]       y0_reg;
    logic [V_BITS-1:0]       y1_reg;
    logic [COLOR_BITS-1:0]   buf0 [32];
    logic [COLOR_BITS-1:0]   buf1 [32];
    logic [COLOR_BITS-1:0]   pix_reg;
    logic [COLOR_BITS-1:0]   pix_next;

    // Differences carry an extra MSB so a negative offset shows up as a borrow.
    logic [V_BITS:0] dy0, dy1;
    logic [H_BITS:0] dx0, dx1;
    logic            row_hit0, row_hit1, col_hit0, col_hit1;
    logic [COLOR_BITS-1:0] px0, px1;

    assign dy0      = {1'b0, next_line} - {1'b0, y0_reg};
    assign dy1      = {1'b0, next_line} - {1'b0, y1_reg};
    assign row_hit0 = en0_reg && !dy0[V_BITS] && (dy0[V_BITS-1:5] == '0);
    assign row_hit1 = en1_reg && !dy1[V_BITS] && (dy1[V_BITS-1:5] == '0);

    assign dx0      = {1'b0, hcount} - {1'b0, x0_reg};
    assign dx1      = {1'b0, hcount} - {1'b0, x1_reg};
    assign col_hit0 = hit0_reg && !dx0[H_BITS] && (dx0[H_BITS-1:5] == '0);
    assign col_hit1 = hit1_reg && !dx1[H_BITS] && (dx1[H_BITS-1:5] == '0);
    assign px0      = buf0[dx0[4:0]];
    assign px1      = buf1[dx1[4:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            col_reg     <= '0;
            row0_reg    <= '0;
            row1_reg    <= '0;
            hit0_reg    <= 1'b0;
            hit1_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            en0_reg     <= 1'b0;
            en1_reg     <= 1'b0;
            x0_reg      <= '0;
            x1_reg      <= '0;
            y0_reg      <= '0;
            y1_reg      <= '0;
        end else begin
            overrun_reg <= 1'b0;
            if (line_start) begin
                // A new blank always restarts the sequence; flag it if one was in flight.
                overrun_reg <= (state_reg != IDLE);
                state_reg   <= CHECK0;
                hit0_reg    <= 1'b0;
                hit1_reg    <= 1'b0;
                col_reg     <= '0;
            end else begin
                case (state_reg)
                    CHECK0: begin
                        hit0_reg  <= row_hit0;
                        row0_reg  <= dy0[4:0];
                        col_reg   <= '0;
                        state_reg <= row_hit0 ? FETCH0 : CHECK1;
                    end
                    FETCH0: begin
                        col_reg <= col_reg + 5'd1;
                        if (col_reg == 5'd31) state_reg <= CHECK1;
                    end
                    CHECK1: begin
                        hit1_reg  <= row_hit1;
                        row1_reg  <= dy1[4:0];
                        col_reg   <= '0;
                        state_reg <= row_hit1 ? FETCH1 : IDLE;
                    end
                    FETCH1: begin
                        col_reg <= col_reg + 5'd1;
                        if (col_reg == 5'd31) state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
            if (frame_start) begin
                en0_reg <= p0_en;
                en1_reg <= p1_en;
                x0_reg  <= p0_x;
                x1_reg  <= p1_x;
                y0_reg  <= p0_y;
                y1_reg  <= p1_y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                buf0[i] <= '0;
                buf1[i] <= '0;
            end
        end else if (!line_start) begin
            if (state_reg == FETCH0) buf0[col_reg] <= rom_data;
            if (state_reg == FETCH1) buf1[col_reg] <= rom_data;
        end
    end

    always_comb begin
        rom_addr = '0;
        case (state_reg)
            FETCH0:  rom_addr = ADDRESS'({1'b0, row0_reg, col_reg});
            FETCH1:  rom_addr = ADDRESS'({1'b1, row1_reg, col_reg});
            default: rom_addr = '0;
        endcase
    end

    // Sprites are hidden while their buffers are being rewritten.
    always_comb begin
        pix_next = bg_color;
        if (!active)                                 pix_next = '0;
        else if (state_reg != IDLE)                  pix_next = bg_color;
        else if (col_hit0 && px0 != TRANSPARENT)     pix_next = px0;
        else if (col_hit1 && px1 != TRANSPARENT)     pix_next = px1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pix_reg <= '0;
        else     pix_reg <= pix_next;
    end

    assign pix_color  = pix_reg;
    assign fetch_busy = (state_reg != IDLE);
    assign overrun    = overrun_reg;
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Randomised self-checking bench for sprite_line_fetcher using a ROM array and a
// per-line behavioural model of row selection and pixel compositing.
module tb_sprite_line_fetcher;
    localparam logic [23:0] TRANSP = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, line_start, active;
    logic [9:0]  next_line, hcount;
    logic        p0_en, p1_en;
    logic [9:0]  p0_x, p1_x, p0_y, p1_y;
    logic [23:0] bg_color, rom_data, pix_color;
    logic [10:0] rom_addr;
    logic        fetch_busy, overrun;

    logic [23:0] rom [0:2047];
    assign rom_data = rom[rom_addr];

    int checks = 0;
    int errors = 0;

    // Model state: shadow positions and the hits of the last fetched line.
    bit m_en0, m_en1;
    int m_x0, m_x1, m_y0, m_y1;
    bit m_h0, m_h1;
    int m_r0, m_r1;

    sprite_line_fetcher dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
        .next_line(next_line), .active(active), .hcount(hcount),
        .p0_en(p0_en), .p1_en(p1_en), .p0_x(p0_x), .p1_x(p1_x),
        .p0_y(p0_y), .p1_y(p1_y), .bg_color(bg_color), .rom_addr(rom_addr),
        .rom_data(rom_data), .pix_color(pix_color), .fetch_busy(fetch_busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic bit row_hit(bit en, int y, int nl);
        return en && (nl >= y) && (nl - y < 32);
    endfunction

    function automatic logic [23:0] model_pix(bit act, int hc, logic [23:0] bg);
        logic [23:0] c;
        if (!act) return 24'h0;
        if (m_h0 && hc >= m_x0 && hc - m_x0 < 32) begin
            c = rom[m_r0 * 32 + (hc - m_x0)];
            if (c != TRANSP) return c;
        end
        if (m_h1 && hc >= m_x1 && hc - m_x1 < 32) begin
            c = rom[1024 + m_r1 * 32 + (hc - m_x1)];
            if (c != TRANSP) return c;
        end
        return bg;
    endfunction

    task automatic set_line_model(int nl);
        m_h0 = row_hit(m_en0, m_y0, nl);
        m_h1 = row_hit(m_en1, m_y1, nl);
        m_r0 = m_h0 ? nl - m_y0 : 0;
        m_r1 = m_h1 ? nl - m_y1 : 0;
    endtask

    task automatic load_frame(bit e0, int x0, int y0, bit e1, int x1, int y1);
        p0_en = e0; p0_x = 10'(x0); p0_y = 10'(y0);
        p1_en = e1; p1_x = 10'(x1); p1_y = 10'(y1);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        m_en0 = e0; m_x0 = x0; m_y0 = y0;
        m_en1 = e1; m_x1 = x1; m_y1 = y1;
    endtask

    // Runs one horizontal-blank fetch, checking the ROM address trace, busy
    // length, absence of overrun and background-only output while busy.
    task automatic do_line(input int nl, output int busy_cycles);
        int          exp_q[$];
        int          n;
        logic [23:0] pbg;
        set_line_model(nl);
        exp_q.push_back(0);
        if (m_h0) for (int c = 0; c < 32; c++) exp_q.push_back(m_r0 * 32 + c);
        exp_q.push_back(0);
        if (m_h1) for (int c = 0; c < 32; c++) exp_q.push_back(1024 + m_r1 * 32 + c);

        next_line = 10'(nl); line_start = 1'b1; active = 1'b0;
        @(posedge clk); #1;
        line_start = 1'b0;
        n = 0;
        pbg = 24'h0;
        while (fetch_busy === 1'b1 && n < 100) begin
            checks++;
            if (n >= exp_q.size() || int'(rom_addr) != exp_q[n]) begin
                errors++;
                $display("FAIL fetch_addr line=%0d cyc=%0d got %h exp %h", nl, n, rom_addr,
                         (n < exp_q.size()) ? exp_q[n] : -1);
            end
            checks++;
            if (overrun !== 1'b0) begin
                errors++;
                $display("FAIL fetch_overrun line=%0d cyc=%0d got %b exp 0", nl, n, overrun);
            end
            checks++;
            if (pix_color !== ((n == 0) ? 24'h0 : pbg)) begin
                errors++;
                $display("FAIL busy_pix line=%0d cyc=%0d got %h exp %h", nl, n, pix_color,
                         (n == 0) ? 24'h0 : pbg);
            end
            pbg = 24'($urandom);
            bg_color = pbg; active = 1'b1; hcount = 10'($urandom);
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != exp_q.size()) begin
            errors++;
            $display("FAIL busy_len line=%0d got %0d exp %0d", nl, n, exp_q.size());
        end
        checks++;
        if (n > 0 && pix_color !== pbg) begin
            errors++;
            $display("FAIL last_busy_pix line=%0d got %h exp %h", nl, pix_color, pbg);
        end
        checks++;
        if (rom_addr !== 11'h0) begin
            errors++;
            $display("FAIL idle_addr line=%0d got %h exp 000", nl, rom_addr);
        end
        active = 1'b0;
        busy_cycles = n;
        $display("line %0d fetched: hit0=%0b hit1=%0b busy=%0d", nl, m_h0, m_h1, n);
    endtask

    task automatic sweep(int lo, int hi);
        logic [23:0] bg, expv;
        bit          act;
        for (int hc = lo; hc <= hi; hc++) begin
            if (hc < 0 || hc > 1023) continue;
            act = ($urandom_range(7) != 0);
            bg  = 24'($urandom);
            active = act; hcount = 10'(hc); bg_color = bg;
            expv = model_pix(act, hc, bg);
            @(posedge clk); #1;
            checks++;
            if (pix_color !== expv) begin
                errors++;
                $display("FAIL pix hc=%0d act=%0b got %h exp %h", hc, act, pix_color, expv);
            end
        end
        active = 1'b0;
        $display("sweep hcount %0d..%0d done", lo, hi);
    endtask

    task automatic check_val(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, expv);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_addr", 32'(rom_addr), 32'h0);
        check_val("reset_pix", 32'(pix_color), 32'h0);
        check_val("reset_busy", 32'(fetch_busy), 32'h0);
        check_val("reset_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_row_fetch;
        int bc;
        load_frame(1, 100, 50, 0, 0, 0);
        do_line(53, bc);
        check_val("row_fetch_busy34", 32'(bc), 32'd34);
        sweep(97, 134);
    endtask

    task automatic test_overlap;
        int bc;
        rom[0] = 24'hFF0000; rom[1024] = 24'h00FF00;
        load_frame(1, 200, 200, 1, 200, 200);
        do_line(200, bc);
        active = 1'b1; hcount = 10'd200; bg_color = 24'h123456;
        @(posedge clk); #1;
        check_val("overlap_s0_wins", 32'(pix_color), 32'hFF0000);
        rom[0] = TRANSP;
        do_line(200, bc);
        active = 1'b1; hcount = 10'd200; bg_color = 24'h123456;
        @(posedge clk); #1;
        check_val("overlap_s1_through", 32'(pix_color), 32'h00FF00);
        sweep(198, 233);
    endtask

    task automatic test_boundary;
        int bc;
        load_frame(1, 100, 50, 0, 0, 0);
        do_line(49, bc);
        check_val("row49_nohit", 32'(bc), 32'd2);
        do_line(82, bc);
        check_val("row82_nohit", 32'(bc), 32'd2);
        do_line(81, bc);
        check_val("row81_hit", 32'(bc), 32'd34);
        sweep(98, 133);
        load_frame(1, 100, 1000, 0, 0, 0);
        do_line(5, bc);
        check_val("nowrap_nohit", 32'(bc), 32'd2);
        sweep(98, 102);
    endtask

    task automatic test_overrun;
        int n;
        load_frame(1, 100, 50, 0, 0, 0);
        next_line = 10'd53; line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        check_val("overrun_pre_addr", 32'(rom_addr), 32'h073);
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        check_val("overrun_pulse", 32'(overrun), 32'h1);
        check_val("overrun_check0_addr", 32'(rom_addr), 32'h0);
        check_val("overrun_busy", 32'(fetch_busy), 32'h1);
        @(posedge clk); #1;
        check_val("overrun_one_cycle", 32'(overrun), 32'h0);
        check_val("overrun_restart_addr", 32'(rom_addr), 32'h060);
        n = 0;
        while (fetch_busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("overrun_completes", 32'(n), 32'd33);
        set_line_model(53);
        sweep(98, 133);
    endtask

    task automatic test_reset_mid_fetch;
        int bc;
        load_frame(1, 100, 50, 0, 0, 0);
        next_line = 10'd53; line_start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            line_start = 1'b0;
        end
        check_val("midreset_pre_addr", 32'(rom_addr), 32'h06A);
        active = 1'b1; bg_color = 24'hABCDEF; hcount = 10'd110;
        rst = 1'b1;
        #1;
        check_val("midreset_addr", 32'(rom_addr), 32'h0);
        check_val("midreset_busy", 32'(fetch_busy), 32'h0);
        check_val("midreset_pix", 32'(pix_color), 32'h0);
        check_val("midreset_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        check_val("midreset_pix_active", 32'(pix_color), 32'h0);
        rst = 1'b0; active = 1'b0;
        m_en0 = 0; m_en1 = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
        m_h0 = 0; m_h1 = 0;
        @(posedge clk); #1;
        do_line(53, bc);
        check_val("midreset_shadow_cleared", 32'(bc), 32'd2);
        sweep(98, 133);
    endtask

    task automatic test_tearing;
        int bc;
        load_frame(1, 100, 50, 0, 0, 0);
        p0_x = 10'd300;
        do_line(60, bc);
        sweep(98, 133);
        sweep(298, 333);
        load_frame(1, 300, 50, 0, 0, 0);
        do_line(60, bc);
        sweep(98, 133);
        sweep(298, 333);
    endtask

    task automatic test_random;
        int bc, nl, x0, x1, y0, y1;
        bit e0, e1;
        for (int it = 0; it < 8; it++) begin
            x0 = $urandom_range(1023); x1 = $urandom_range(1023);
            y0 = $urandom_range(1023); y1 = $urandom_range(1023);
            e0 = ($urandom_range(3) != 0); e1 = ($urandom_range(3) != 0);
            if (it % 3 == 0) begin
                y1 = y0 + int'($urandom_range(20)) - 10;
                if (y1 < 0) y1 = 0;
                if (y1 > 1023) y1 = 1023;
                x1 = x0 + int'($urandom_range(30)) - 15;
                if (x1 < 0) x1 = 0;
                if (x1 > 1023) x1 = 1023;
            end
            nl = (($urandom_range(1) == 0) ? y0 : y1) + int'($urandom_range(36)) - 2;
            if (nl < 0) nl = 0;
            if (nl > 1023) nl = 1023;
            load_frame(e0, x0, y0, e1, x1, y1);
            do_line(nl, bc);
            sweep(x0 - 2, x0 + 33);
            sweep(x1 - 2, x1 + 33);
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; active = 1'b0;
        next_line = '0; hcount = '0; bg_color = '0;
        p0_en = 1'b0; p1_en = 1'b0; p0_x = '0; p1_x = '0; p0_y = '0; p1_y = '0;
        m_en0 = 0; m_en1 = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
        m_h0 = 0; m_h1 = 0; m_r0 = 0; m_r1 = 0;
        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(3) == 0) ? TRANSP : 24'($urandom);

        test_reset;
        test_row_fetch;
        test_overlap;
        test_boundary;
        test_overrun;
        test_reset_mid_fetch;
        test_tearing;
        test_random;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
